// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS controller
package mips_pkg;

  // Controller states; encodings 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // How the ALU operation is chosen
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_t;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True for the R-type function codes the datapath implements
  function automatic logic funct_supported(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_SLT);
  endfunction

endpackage

// File: rtl/mips_aludec.sv
// rtl/mips_aludec.sv - ALU control decode from aluop, opcode and funct
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  // Unknown funct or opcode falls back to add so the datapath stays defined
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      ALUOP_IMM: begin
        case (op)
          OP_ADDI: alucontrol = ALU_ADD;
          OP_SLTI: alucontrol = ALU_SLT;
          OP_ORI:  alucontrol = ALU_OR;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore FSM controller for the multicycle MIPS datapath
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcen,
  output logic        iord,
  output logic        irwrite,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        immzext,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcwrite, branch, irw, memw, regw;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d  = S_FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    irw      = 1'b0;
    memw     = 1'b0;
    regw     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;
    immzext  = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        irw     = 1'b1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_BRIMM;
        case (op)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_BEQ:                   state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ORI: state_d = S_IEXEC;
          OP_J:                     state_d = S_JUMP;
          OP_RTYPE: begin
            // Unknown funct is flagged but still runs as an add
            state_d = S_EXEC;
            illegal = ~funct_supported(funct);
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regw     = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        memw = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        regw   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_IMM;
        immzext = (op == OP_ORI);
        state_d = S_IWB;
      end
      S_IWB: begin
        regw = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural write strobes are suppressed while reset is held
  always_comb begin
    pcen     = (pcwrite | (branch & zero)) & ~reset;
    irwrite  = irw & ~reset;
    memwrite = memw & ~reset;
    regwrite = regw & ~reset;
    state    = state_q;
  end

  mips_aludec u_aludec (
    .aluop      (aluop),
    .op         (op),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       immzext, illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [20:0] obs;
  logic [20:0] ev;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .immzext    (immzext),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, alucontrol, immzext, illegal};

  // Reference model: instruction classes and their state walks

  function automatic bit is_legal_op(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 ||
           o == 6'b001000 || o == 6'b001010 || o == 6'b001101 || o == 6'b000010;
  endfunction

  function automatic bit is_legal_funct(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  // Total cycles for one instruction, counting FETCH
  function automatic int path_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000, 6'b001010, 6'b001101: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  // State number visited at cycle c of the instruction
  function automatic int path_state(input logic [5:0] o, input int c);
    int walk [3];
    walk = '{0, 0, 0};
    case (o)
      6'b100011: walk = '{2, 3, 4};
      6'b101011: walk = '{2, 5, 0};
      6'b000000: walk = '{6, 7, 0};
      6'b000100: walk = '{8, 0, 0};
      6'b001000, 6'b001010, 6'b001101: walk = '{9, 10, 0};
      6'b000010: walk = '{11, 0, 0};
      default: walk = '{0, 0, 0};
    endcase
    if (c < 2) return c;
    return walk[c-2];
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output bundle for a state number, packed like obs
  function automatic logic [20:0] exp_vec(input int st, input logic [5:0] o,
                                          input logic [5:0] f, input logic z,
                                          input logic rst);
    logic pw, br, io, irw, mw, rw, rd, m2r, asa, imm, ill, pce;
    logic [1:0] asb, pcs;
    logic [2:0] alc;
    logic [3:0] stv;
    pw = 0; br = 0; io = 0; irw = 0; mw = 0; rw = 0; rd = 0; m2r = 0;
    asa = 0; imm = 0; ill = 0; asb = 2'b00; pcs = 2'b00; alc = 3'b010;
    stv = 4'(st);
    case (st)
      0:  begin asb = 2'b01; irw = 1; pw = 1; end
      1:  begin asb = 2'b11; ill = !is_legal_op(o) || (o == 6'b000000 && !is_legal_funct(f)); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; alc = rtype_alu(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; alc = 3'b110; pcs = 2'b01; br = 1; end
      9:  begin
            asa = 1; asb = 2'b10;
            alc = (o == 6'b001010) ? 3'b111 : (o == 6'b001101) ? 3'b001 : 3'b010;
            imm = (o == 6'b001101);
          end
      10: rw = 1;
      11: begin pcs = 2'b10; pw = 1; end
      default: ;
    endcase
    pce = pw | (br & z);
    if (rst) begin pce = 0; irw = 0; mw = 0; rw = 0; end
    return {stv, pce, io, irw, mw, rw, rd, m2r, asa, asb, pcs, alc, imm, ill};
  endfunction

  task automatic test_reset();
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    ev = exp_vec(0, op, funct, zero, 1'b1);
    if (obs !== ev) begin errors++; $display("FAIL reset_held got %h exp %h", obs, ev); end
    reset = 1'b0;
    #1;
    checks++;
    ev = exp_vec(0, op, funct, zero, 1'b0);
    if (obs !== ev) begin errors++; $display("FAIL reset_release got %h exp %h", obs, ev); end
  endtask

  task automatic test_lw();
    op = 6'b100011; funct = 6'($urandom); zero = 1'($urandom);
    for (int c = 0; c < path_len(op); c++) begin
      #1;
      checks++;
      ev = exp_vec(path_state(op, c), op, funct, zero, 1'b0);
      if (obs !== ev) begin errors++; $display("FAIL lw c=%0d got %h exp %h", c, obs, ev); end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      op = 6'b000100; funct = 6'($urandom); zero = (k == 0);
      for (int c = 0; c < path_len(op); c++) begin
        #1;
        checks++;
        ev = exp_vec(path_state(op, c), op, funct, zero, 1'b0);
        if (obs !== ev) begin errors++; $display("FAIL beq z=%0d c=%0d got %h exp %h", zero, c, obs, ev); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fl [7];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111, 6'b000111};
    for (int k = 0; k < 7; k++) begin
      op = 6'b000000; funct = fl[k]; zero = 1'($urandom);
      for (int c = 0; c < path_len(op); c++) begin
        #1;
        checks++;
        ev = exp_vec(path_state(op, c), op, funct, zero, 1'b0);
        if (obs !== ev) begin errors++; $display("FAIL rtype f=%b c=%0d got %h exp %h", funct, c, obs, ev); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] ol [4];
    ol = '{6'b001101, 6'b001010, 6'b001000, 6'b101011};
    for (int k = 0; k < 4; k++) begin
      op = ol[k]; funct = 6'($urandom); zero = 1'($urandom);
      for (int c = 0; c < path_len(op); c++) begin
        #1;
        checks++;
        ev = exp_vec(path_state(op, c), op, funct, zero, 1'b0);
        if (obs !== ev) begin errors++; $display("FAIL itype op=%b c=%0d got %h exp %h", op, c, obs, ev); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ol [3];
    ol = '{6'b111111, 6'b000010, 6'b010101};
    for (int k = 0; k < 3; k++) begin
      op = ol[k]; funct = 6'($urandom); zero = 1'($urandom);
      for (int c = 0; c < path_len(op); c++) begin
        #1;
        checks++;
        ev = exp_vec(path_state(op, c), op, funct, zero, 1'b0);
        if (obs !== ev) begin errors++; $display("FAIL illegal_op op=%b c=%0d got %h exp %h", op, c, obs, ev); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b101011; funct = 6'd0; zero = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      ev = exp_vec(path_state(op, c), op, funct, zero, 1'b0);
      if (obs !== ev) begin errors++; $display("FAIL midrst_pre c=%0d got %h exp %h", c, obs, ev); end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    ev = exp_vec(5, op, funct, zero, 1'b1);
    if (obs !== ev) begin errors++; $display("FAIL midrst_memwr got %h exp %h", obs, ev); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      ev = exp_vec(0, op, funct, zero, 1'b1);
      if (obs !== ev) begin errors++; $display("FAIL midrst_held c=%0d got %h exp %h", c, obs, ev); end
    end
    reset = 1'b0;
    #1;
    checks++;
    ev = exp_vec(0, op, funct, zero, 1'b0);
    if (obs !== ev) begin errors++; $display("FAIL midrst_release got %h exp %h", obs, ev); end
  endtask

  task automatic test_back_to_back(input int n);
    logic [5:0] legal [8];
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b001000, 6'b001010, 6'b001101, 6'b000010};
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 8) == 0) begin
        do op = 6'($urandom); while (is_legal_op(op));
      end else begin
        op = legal[$urandom_range(0, 7)];
      end
      funct = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                          : rtype_pick($urandom_range(0, 4));
      for (int c = 0; c < path_len(op); c++) begin
        zero = 1'($urandom);
        #1;
        checks++;
        ev = exp_vec(path_state(op, c), op, funct, zero, 1'b0);
        if (obs !== ev) begin errors++; $display("FAIL b2b k=%0d op=%b f=%b c=%0d got %h exp %h", k, op, funct, c, obs, ev); end
        @(negedge clk);
      end
    end
  endtask

  function automatic logic [5:0] rtype_pick(input int i);
    case (i)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      default: return 6'b101010;
    endcase
  endfunction

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_rtype();
    test_itype();
    test_illegal();
    test_reset_mid();
    test_back_to_back(150);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
